multicycle_adder: RTL and testbench
===================================

# multicycle_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It reports carry or borrow out and signed overflow. A start/busy/done handshake controls each operation. It is the sequential, wide-operand successor to the team's single-bit adder, for datapaths that trade latency for area.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration-time check).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a new operation; sampled only while busy=0.
- mode  input  1  0 = add (a + b + cin), 1 = subtract (a − b − cin).
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in (add) or borrow-in (subtract); captured with the operands.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum, cout and ovf become valid.
- sum  output  WIDTH  result.
- cout  output  1  add: carry out of the MSB. Subtract: borrow, 1 when unsigned a < b + cin.
- ovf  output  1  two's-complement signed overflow of the result.

## Operation
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- On rst_n low, immediately and asynchronously:
  - state = IDLE, digit counter = 0.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal operand and carry registers are cleared.
- IDLE/DONE → RUN on start=1:
  - Latch a.
  - Latch b, inverted when mode=1.
  - Internal carry initialised to cin when mode=0, to ~cin when mode=1.
  - Counter = 0.
- RUN, each cycle:
  - Add the least-significant DIGIT bits of the operands and the carry.
  - Shift the sum digit into the result register from the MSB side.
  - Shift both operands right by DIGIT.
  - Update the carry; counter increments.
- RUN → DONE after NDIG = WIDTH/DIGIT digit cycles. On that same edge:
  - sum is registered.
  - cout = carry (mode=0) or ~carry (mode=1).
  - ovf = carry into MSB XOR carry out of MSB.
- DONE lasts exactly one cycle (done=1), then returns to IDLE unless start=1.
- start while busy=1 is ignored. Operand changes while busy have no effect.
- sum, cout and ovf hold their last values until the next DONE, and do not change during RUN.

## Timing
- Accepted start at edge k:
  - busy = 1 from after edge k through edge k+NDIG.
  - done = 1 and results valid for the cycle after edge k+NDIG.
  - Latency is NDIG cycles; throughput is one operation per NDIG+1 cycles.
- start during the done cycle is accepted: back-to-back operations with no idle gap.
- rst_n asserted mid-RUN aborts the operation. No done pulse is produced for the aborted operation, and outputs return to reset values.
- DIGIT = WIDTH gives a single-cycle compute with latency 1.

## Structure
- Shared package: state encoding typedef (IDLE, RUN, DONE) and the mode constants MODE_ADD, MODE_SUB.
- Sub-module digit_adder:
  - Parameter DIGIT.
  - Combinational DIGIT-bit ripple adder with inputs x, y, ci.
  - Outputs s, co, and c_msb, the carry into its top bit, used for ovf on the final digit.
- Top level contains the FSM, the counter sized $clog2(NDIG+1), and the shift registers.

## Test plan
- WIDTH=8, DIGIT=1, add 0x0F + 0x01, cin=0 → after 8 busy cycles, done pulse, sum=0x10, cout=0, ovf=0.
- Add 0x7F + 0x01 → sum=0x80, ovf=1, cout=0. Add 0xFF + 0x00, cin=1 → sum=0x00, cout=1, ovf=0.
- Subtract 0x05 − 0x07, cin=0 → sum=0xFE, cout=1 (borrow), ovf=0. Subtract 0x80 − 0x01 → sum=0x7F, ovf=1, cout=0.
- start held high for 20 cycles with operands changing every cycle:
  - Only the operands present at each accepted start are used.
  - Done pulses occur every 9 cycles.
- Reset pulse during the 4th RUN cycle → all outputs 0 immediately, no done. A new start afterwards gives the correct result.
- WIDTH=16, DIGIT=4:
  - Random 1000 operations, both modes, checked against a reference model.
  - Latency is exactly 4 cycles per operation.

Source files
------------

// File: rtl/multicycle_adder_pkg.sv
// Shared types and constants for the multi-cycle adder/subtractor.
package multicycle_adder_pkg;

  // Controller states: waiting, stepping through digits, one-cycle result strobe.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation select on the mode input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/multicycle_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder. Besides the carry out it exposes the
// carry into its top bit so the caller can form signed overflow on the last digit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic carry;

  // Ripple the carry bit by bit; c_msb ends up as the carry entering bit DIGIT-1.
  always_comb begin
    carry = ci;
    c_msb = ci;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: consumes a WIDTH-bit operand pair DIGIT bits per
// clock, least-significant digit first, behind a start/busy/done handshake.
// Subtraction is done as a + ~b + ~cin so a single adder serves both modes.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  // Reject parameter sets the digit-serial datapath cannot handle.
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("multicycle_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_shift;
  logic             last_digit;
  logic             accept;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the MSB; after NDIG shifts the register holds the full result.
  assign res_shift  = WIDTH'({dig_s, res_q} >> DIGIT);
  assign last_digit = (cnt_q == LAST_DIGIT);
  assign accept     = start && (state_q != ST_RUN);

  // Next-state logic: start is honoured from IDLE and from the DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, step one digit per RUN cycle,
  // and publish sum/cout/ovf only on the final digit so they hold otherwise.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = (mode == MODE_SUB) ? ~b : b;
      carry_d = (mode == MODE_SUB) ? ~cin : cin;
      mode_d  = mode;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      res_d   = res_shift;
      carry_d = dig_co;
      cnt_d   = cnt_q + CW'(1);
      if (last_digit) begin
        sum_d  = res_shift;
        // In subtract mode a carry out means "no borrow", so invert it.
        cout_d = (mode_q == MODE_SUB) ? ~dig_co : dig_co;
        ovf_d  = dig_cmsb ^ dig_co;
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: an 8-bit digit-serial instance (DIGIT=1) and a
// 16-bit radix-16 instance (DIGIT=4), checked against an arithmetic model.
module tb_multicycle_adder;
  import multicycle_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8_start = 1'b0, s8_mode = 1'b0, s8_cin = 1'b0;
  logic [7:0] s8_a = '0, s8_b = '0;
  logic       s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_sum;

  logic        s16_start = 1'b0, s16_mode = 1'b0, s16_cin = 1'b0;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic        s16_busy, s16_done, s16_cout, s16_ovf;
  logic [15:0] s16_sum;

  multicycle_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .mode(s8_mode),
    .a(s8_a), .b(s8_b), .cin(s8_cin),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .mode(s16_mode),
    .a(s16_a), .b(s16_b), .cin(s16_cin),
    .busy(s16_busy), .done(s16_done), .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf)
  );

  int checks = 0;
  int failures = 0;

  // Result each DUT is expected to be holding between operations.
  logic [7:0]  last8_s = '0;
  logic        last8_c = 1'b0, last8_v = 1'b0;
  logic [15:0] last16_s = '0;
  logic        last16_c = 1'b0, last16_v = 1'b0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec8_t;

  // Reference: exact integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic m, input logic c,
                                output logic [15:0] s, output logic co, output logic ov);
    int lim, ua, ub, sa, sb, ur, sr;
    lim = 1 << w;
    ua  = int'(a) & (lim - 1);
    ub  = int'(b) & (lim - 1);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    if (m == MODE_ADD) begin
      ur = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      co = (ur >= lim);
    end else begin
      ur = ua - ub - int'(c);
      sr = sa - sb - int'(c);
      co = (ua < ub + int'(c));
    end
    s  = 16'(ur & (lim - 1));
    ov = (sr > lim / 2 - 1) || (sr < -(lim / 2));
  endfunction

  // One 8-bit operation, entered and left on a falling edge; start is driven at entry.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic m, input logic c,
                         input logic [7:0] es, input logic eco, input logic eov);
    s8_a = a; s8_b = b; s8_mode = m; s8_cin = c; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom); s8_b = 8'($urandom); s8_mode = 1'($urandom); s8_cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (s8_busy !== 1'b1 || s8_done !== 1'b0 || s8_sum !== last8_s ||
          s8_cout !== last8_c || s8_ovf !== last8_v) begin
        failures++;
        $display("FAIL run8 cycle %0d: busy=%b done=%b sum=%h cout=%b ovf=%b, required busy=1 done=0 sum=%h cout=%b ovf=%b",
                 i, s8_busy, s8_done, s8_sum, s8_cout, s8_ovf, last8_s, last8_c, last8_v);
      end
    end
    @(negedge clk);
    checks++;
    if (s8_done !== 1'b1 || s8_busy !== 1'b0 || s8_sum !== es || s8_cout !== eco || s8_ovf !== eov) begin
      failures++;
      $display("FAIL result8 a=%h b=%h mode=%b cin=%b: done=%b busy=%b sum=%h cout=%b ovf=%b, required done=1 busy=0 sum=%h cout=%b ovf=%b",
               a, b, m, c, s8_done, s8_busy, s8_sum, s8_cout, s8_ovf, es, eco, eov);
    end
    $display("op8  a=%h b=%h mode=%b cin=%b -> sum=%h cout=%b ovf=%b", a, b, m, c, s8_sum, s8_cout, s8_ovf);
    last8_s = es; last8_c = eco; last8_v = eov;
  endtask

  // One 16-bit operation: exactly four busy cycles, then the done cycle.
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic m, input logic c);
    logic [15:0] es;
    logic        eco, eov;
    model(16, a, b, m, c, es, eco, eov);
    s16_a = a; s16_b = b; s16_mode = m; s16_cin = c; s16_start = 1'b1;
    @(posedge clk); #1;
    s16_start = 1'b0;
    s16_a = 16'($urandom); s16_b = 16'($urandom); s16_mode = 1'($urandom); s16_cin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (s16_busy !== 1'b1 || s16_done !== 1'b0 || s16_sum !== last16_s ||
          s16_cout !== last16_c || s16_ovf !== last16_v) begin
        failures++;
        $display("FAIL run16 cycle %0d: busy=%b done=%b sum=%h, required busy=1 done=0 sum=%h",
                 i, s16_busy, s16_done, s16_sum, last16_s);
      end
    end
    @(negedge clk);
    checks++;
    if (s16_done !== 1'b1 || s16_busy !== 1'b0 || s16_sum !== es || s16_cout !== eco || s16_ovf !== eov) begin
      failures++;
      $display("FAIL result16 a=%h b=%h mode=%b cin=%b: done=%b busy=%b sum=%h cout=%b ovf=%b, required done=1 busy=0 sum=%h cout=%b ovf=%b",
               a, b, m, c, s16_done, s16_busy, s16_sum, s16_cout, s16_ovf, es, eco, eov);
    end
    $display("op16 a=%h b=%h mode=%b cin=%b -> sum=%h cout=%b ovf=%b", a, b, m, c, s16_sum, s16_cout, s16_ovf);
    last16_s = es; last16_c = eco; last16_v = eov;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s8_busy, s8_done, s8_cout, s8_ovf} !== 4'b0 || s8_sum !== 8'h00 ||
        {s16_busy, s16_done, s16_cout, s16_ovf} !== 4'b0 || s16_sum !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: dut8 busy=%b done=%b sum=%h cout=%b ovf=%b dut16 busy=%b done=%b sum=%h, required all zero",
               s8_busy, s8_done, s8_sum, s8_cout, s8_ovf, s16_busy, s16_done, s16_sum);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s16_busy !== 1'b0 || s16_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy8=%b done8=%b busy16=%b done16=%b, required all 0",
               s8_busy, s8_done, s16_busy, s16_done);
    end
  endtask

  task automatic test_directed8();
    vec8_t tv [5];
    tv[0] = '{8'h0F, 8'h01, MODE_ADD, 1'b0, 8'h10, 1'b0, 1'b0};
    tv[1] = '{8'h7F, 8'h01, MODE_ADD, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[2] = '{8'hFF, 8'h00, MODE_ADD, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[3] = '{8'h05, 8'h07, MODE_SUB, 1'b0, 8'hFE, 1'b1, 1'b0};
    tv[4] = '{8'h80, 8'h01, MODE_SUB, 1'b0, 8'h7F, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) run_op8(tv[i].a, tv[i].b, tv[i].m, tv[i].c, tv[i].s, tv[i].co, tv[i].ov);
    // done must be a single-cycle pulse with results held afterwards.
    @(negedge clk);
    checks++;
    if (s8_done !== 1'b0 || s8_busy !== 1'b0 || s8_sum !== 8'h7F || s8_ovf !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b sum=%h ovf=%b, required done=0 busy=0 sum=7f ovf=1",
               s8_done, s8_busy, s8_sum, s8_ovf);
    end
  endtask

  task automatic test_random8();
    logic [15:0] es;
    logic        eco, eov;
    logic [7:0]  a, b;
    logic        m, c;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); c = 1'($urandom);
      model(8, {8'h00, a}, {8'h00, b}, m, c, es, eco, eov);
      run_op8(a, b, m, c, es[7:0], eco, eov);
    end
  endtask

  // start held for 20 cycles with fresh operands every cycle: accepts at cycles 0, 9, 18.
  task automatic test_back_to_back8();
    logic [15:0] es [3];
    logic        eco [3], eov [3];
    logic        exp_busy, exp_done;
    int          k;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(negedge clk);
        exp_done = (c == 9) || (c == 18) || (c == 27);
        exp_busy = (((c - 1) % 9) <= 7) && ((c - 1) <= 25);
        checks++;
        if (s8_busy !== exp_busy || s8_done !== exp_done) begin
          failures++;
          $display("FAIL b2b_handshake cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                   c, s8_busy, s8_done, exp_busy, exp_done);
        end
        if (exp_done) begin
          k = (c - 9) / 9;
          checks++;
          if (s8_sum !== es[k][7:0] || s8_cout !== eco[k] || s8_ovf !== eov[k]) begin
            failures++;
            $display("FAIL b2b_result op %0d: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     k, s8_sum, s8_cout, s8_ovf, es[k][7:0], eco[k], eov[k]);
          end
          $display("b2b op %0d -> sum=%h cout=%b ovf=%b", k, s8_sum, s8_cout, s8_ovf);
          last8_s = es[k][7:0]; last8_c = eco[k]; last8_v = eov[k];
        end
      end
      if (c < 20) begin
        s8_start = 1'b1;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_mode = 1'($urandom); s8_cin = 1'($urandom);
        if (c % 9 == 0) model(8, {8'h00, s8_a}, {8'h00, s8_b}, s8_mode, s8_cin, es[c / 9], eco[c / 9], eov[c / 9]);
      end else begin
        s8_start = 1'b0;
      end
    end
  endtask

  // Reset during the 4th RUN cycle aborts the operation with no done pulse.
  task automatic test_reset_mid_run();
    logic [15:0] es;
    logic        eco, eov;
    logic        seen_done;
    run_op8(8'h7F, 8'h01, MODE_ADD, 1'b0, 8'h80, 1'b0, 1'b1);
    s8_a = 8'h3C; s8_b = 8'h55; s8_mode = MODE_ADD; s8_cin = 1'b1; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s8_busy, s8_done, s8_cout, s8_ovf} !== 4'b0 || s8_sum !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero",
               s8_busy, s8_done, s8_sum, s8_cout, s8_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last8_s = '0; last8_c = 1'b0; last8_v = 1'b0;
    last16_s = '0; last16_c = 1'b0; last16_v = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s8_done !== 1'b0 || s8_busy !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL abort_no_done: activity seen after aborted operation, required done=0 busy=0 throughout");
    end
    model(8, 16'h00C8, 16'h0037, MODE_SUB, 1'b1, es, eco, eov);
    run_op8(8'hC8, 8'h37, MODE_SUB, 1'b1, es[7:0], eco, eov);
  endtask

  task automatic test_random16();
    for (int i = 0; i < 1000; i++) run_op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_random8();
    test_back_to_back8();
    test_reset_mid_run();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
